audio_source_mixer: RTL and testbench
=====================================

AUDIO_SOURCE_MIXER -- requirements
Module: audio_source_mixer

Interface
REQ-001 Parameters SHALL be, name / default / meaning:
- NUM_SRC / 4 / number of stereo sources (power of two, 2..16).
- DATA_W / 16 / signed two's-complement sample width.
- FADE_STEPS / 16 / fade ramp length in samples (power of two).
REQ-002 Ports SHALL be, name / direction / width / meaning:
- iCLK / in / 1 / system clock.
- iRST_N / in / 1 / reset.
- iSAMPLE_TICK / in / 1 / one-cycle pulse per audio sample.
- iSRC_L / in / NUM_SRC*DATA_W / left samples, source k at bits [k*DATA_W +: DATA_W].
- iSRC_R / in / NUM_SRC*DATA_W / right samples, same packing.
- iSEL / in / clog2(NUM_SRC) / requested source in select mode.
- iMODE / in / 1 / 0 = select one source, 1 = mix all sources.
- iMUTE / in / 1 / fade to silence and hold.
- iVOL / in / 3 / attenuation, arithmetic right shift 0..7.
- oL / out / DATA_W / left output.
- oR / out / DATA_W / right output.
- oVALID / out / 1 / one-cycle pulse when oL/oR update.
- oFADING / out / 1 / high in states FADE_OUT and FADE_IN.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low (iCLK, iRST_N).

Function
REQ-004 All inputs SHALL be sampled only on cycles where iSAMPLE_TICK=1; on other cycles state and outputs SHALL hold.
REQ-005 oL/oR SHALL be registered and update, with oVALID=1, exactly one cycle after iSAMPLE_TICK.
REQ-006 Raw value SHALL be src[cur_sel] in select mode, or the sum of all sources in mix mode.
REQ-007 The mix-mode sum SHALL be computed at DATA_W+clog2(NUM_SRC) bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-008 Output SHALL be (raw*gain)>>>clog2(FADE_STEPS), then >>>iVOL, both arithmetic shifts with truncation toward negative infinity.
REQ-009 gain SHALL range 0..FADE_STEPS.
REQ-010 FSM states SHALL be IDLE, FADE_OUT, FADE_IN, MUTED; updates occur on iSAMPLE_TICK only.
REQ-011 IDLE: gain=FADE_STEPS.
- If iMUTE=1 -> FADE_OUT.
- Else if iMODE=0 and iSEL!=cur_sel -> latch target=iSEL, then FADE_OUT.
REQ-012 FADE_OUT: gain decrements by 1 per tick; iSEL changes update target only.
- At gain 0 with iMUTE=1 -> MUTED.
- At gain 0 otherwise -> cur_sel=target, then FADE_IN.
REQ-013 FADE_IN: gain increments by 1 per tick; at gain FADE_STEPS -> IDLE.
- If iMUTE=1, or iSEL!=cur_sel in select mode -> FADE_OUT from the current gain, with no jump.
REQ-014 MUTED: gain=0; on iMUTE=0 -> apply a pending target if any, then FADE_IN.
REQ-015 An iMODE change SHALL take effect at the next tick with no fade; cur_sel SHALL be retained for the return to select mode.
REQ-016 If iSEL changes and returns before gain reaches 0, the fade SHALL still complete (out then in) with cur_sel unchanged.

Reset
REQ-017 While iRST_N=0, all of the following SHALL hold:
- oL=0, oR=0, oVALID=0, oFADING=0.
- state=IDLE, cur_sel=0, target=0, gain=FADE_STEPS.
REQ-018 Reset asserted mid-fade SHALL abort immediately to the REQ-017 values; the first tick after release SHALL output source 0 at full gain.

Structure
REQ-019 Package audio_mix_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-020 Saturating summation SHALL be a sub-module audio_sat_sum (parametrised NUM_SRC, DATA_W), instantiated once per channel.

Verification (NUM_SRC=4, DATA_W=16, FADE_STEPS=16)
REQ-021 Reset release, iMODE=0, src0 L=0x1000, tick -> next cycle oL=0x1000, oVALID=1, oFADING=0.
REQ-022 Mix mode, four sources L=0x7000 each -> oL=0x7FFF; four sources L=0x9000 each -> oL=0x8000.
REQ-023 iSEL 0->2 (src0=0x1000, src2=0x2000) -> across 32 ticks:
- oL steps 0x0F00, 0x0E00, ... 0x0000;
- then 0x0200, 0x0400, ... 0x2000;
- oFADING high throughout.
REQ-024 iMUTE=1 in IDLE -> 16 ticks to oL=0, state MUTED; iMUTE=0 -> 16 ticks back to full level.
REQ-025 iVOL=3, raw=-1 (0xFFFF) -> oL=0xFFFF (floor); raw=0x0008 -> oL=0x0001.
REQ-026 iRST_N pulsed low asynchronously mid-FADE_IN -> oL=0, oVALID=0 within the same cycle; the next tick outputs src0.

Source files
------------

// File: rtl/audio_mix_pkg.sv
// -----------------------------------------------------------------------------
// audio_mix_pkg
// Shared definitions for the audio source mixer:
//   - mix_state_e : fade state machine encoding (IDLE, FADE_OUT, FADE_IN, MUTED)
//   - DEF_*       : default parameter values used by the mixer and its bench
// -----------------------------------------------------------------------------
package audio_mix_pkg;

   localparam int unsigned DEF_NUM_SRC    = 4;
   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_FADE_STEPS = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_FADE_IN  = 2'd2,
      ST_MUTED    = 2'd3
   } mix_state_e;

endpackage

// File: rtl/audio_sat_sum.sv
// -----------------------------------------------------------------------------
// audio_sat_sum
// Adds NUM_SRC signed samples at DATA_W+clog2(NUM_SRC) bits (cannot overflow)
// and saturates the result back to the signed DATA_W range.
// Ports:
//   src_i : packed samples, source k at [k*DATA_W +: DATA_W]
//   sum_o : saturated signed sum
// -----------------------------------------------------------------------------
module audio_sat_sum
   import audio_mix_pkg::*;
#(
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_i,
   output logic [DATA_W-1:0]         sum_o
);

   localparam int unsigned SUM_W = DATA_W + $clog2(NUM_SRC);
   localparam int unsigned EXT_W = SUM_W - DATA_W;

   logic [SUM_W-1:0] acc_s;
   logic [EXT_W:0]   top_s;

   // Wide sign-extended accumulation followed by clamp to the output range
   always_comb begin
      acc_s = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         acc_s = acc_s + {{EXT_W{src_i[k*DATA_W + DATA_W - 1]}}, src_i[k*DATA_W +: DATA_W]};
      end
      // The value fits in DATA_W only when all bits above the output sign bit agree
      top_s = acc_s[SUM_W-1:DATA_W-1];
      if ((top_s == {(EXT_W+1){1'b0}}) || (top_s == {(EXT_W+1){1'b1}})) begin
         sum_o = acc_s[DATA_W-1:0];
      end else if (acc_s[SUM_W-1]) begin
         sum_o = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sum_o = {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/audio_source_mixer.sv
// -----------------------------------------------------------------------------
// audio_source_mixer
// Selects one stereo source (or a saturated mix of all sources), applies a
// linear fade gain and a volume shift, and registers the result once per
// audio sample. Source switching and muting fade out/in over FADE_STEPS ticks.
// Ports:
//   iCLK, iRST_N   : clock, asynchronous active-low reset
//   iSAMPLE_TICK   : one-cycle pulse per sample; inputs sampled only then
//   iSRC_L/iSRC_R  : packed left/right sources, source k at [k*DATA_W +: DATA_W]
//   iSEL           : requested source in select mode
//   iMODE          : 0 = select one source, 1 = mix all sources
//   iMUTE          : fade to silence and hold
//   iVOL           : extra attenuation, arithmetic right shift 0..7
//   oL/oR          : registered output samples
//   oVALID         : one-cycle pulse when oL/oR update
//   oFADING        : high while fading out or in
// -----------------------------------------------------------------------------
module audio_source_mixer
   import audio_mix_pkg::*;
#(
   parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FADE_STEPS = DEF_FADE_STEPS
) (
   input  logic                       iCLK,
   input  logic                       iRST_N,
   input  logic                       iSAMPLE_TICK,
   input  logic [NUM_SRC*DATA_W-1:0]  iSRC_L,
   input  logic [NUM_SRC*DATA_W-1:0]  iSRC_R,
   input  logic [$clog2(NUM_SRC)-1:0] iSEL,
   input  logic                       iMODE,
   input  logic                       iMUTE,
   input  logic [2:0]                 iVOL,
   output logic [DATA_W-1:0]          oL,
   output logic [DATA_W-1:0]          oR,
   output logic                       oVALID,
   output logic                       oFADING
);

   localparam int unsigned SEL_W   = $clog2(NUM_SRC);
   localparam int unsigned GAIN_SH = $clog2(FADE_STEPS);
   localparam int unsigned GAIN_W  = GAIN_SH + 1;
   localparam int unsigned PROD_W  = DATA_W + GAIN_W + 1;

   localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(FADE_STEPS);
   localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);
   localparam logic [GAIN_W-1:0] GAIN_ZERO = GAIN_W'(0);

   mix_state_e        state_q, state_d;
   logic [GAIN_W-1:0] gain_q, gain_d;
   logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0]  tgt_q, tgt_d;
   logic [DATA_W-1:0] l_q, l_d;
   logic [DATA_W-1:0] r_q, r_d;
   logic              valid_q, valid_d;
   logic              fading_q, fading_d;

   logic [DATA_W-1:0] sum_l_s, sum_r_s;
   logic [DATA_W-1:0] sel_l_s, sel_r_s;
   logic [DATA_W-1:0] raw_l_s, raw_r_s;

   // (raw * gain) >>> log2(FADE_STEPS), then >>> vol; both floor toward -inf.
   // The product cannot exceed |raw|, so the low DATA_W bits are exact.
   function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] raw,
                                               input logic [GAIN_W-1:0] gain,
                                               input logic [2:0]        vol);
      logic signed [PROD_W-1:0] raw_x;
      logic signed [PROD_W-1:0] gain_x;
      logic signed [PROD_W-1:0] prod;
      raw_x  = {{(PROD_W-DATA_W){raw[DATA_W-1]}}, raw};
      gain_x = {{(PROD_W-GAIN_W){1'b0}}, gain};
      prod   = (raw_x * gain_x) >>> GAIN_SH;
      prod   = prod >>> vol;
      return prod[DATA_W-1:0];
   endfunction

   audio_sat_sum #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_sum_l (
      .src_i (iSRC_L),
      .sum_o (sum_l_s)
   );

   audio_sat_sum #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_sum_r (
      .src_i (iSRC_R),
      .sum_o (sum_r_s)
   );

   // Fade state machine next-state; everything holds unless a tick arrives
   always_comb begin
      state_d   = state_q;
      gain_d    = gain_q;
      cur_sel_d = cur_sel_q;
      tgt_d     = tgt_q;
      if (iSAMPLE_TICK) begin
         case (state_q)
            ST_IDLE: begin
               gain_d = GAIN_FULL;
               if (iMUTE) begin
                  state_d = ST_FADE_OUT;
                  gain_d  = GAIN_FULL - GAIN_ONE;
               end else if (!iMODE && (iSEL != cur_sel_q)) begin
                  tgt_d   = iSEL;
                  state_d = ST_FADE_OUT;
                  gain_d  = GAIN_FULL - GAIN_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FADE_OUT: begin
               // A request that returns to cur_sel still completes out-then-in
               tgt_d = iMODE ? tgt_q : iSEL;
               if (gain_q <= GAIN_ONE) begin
                  gain_d = GAIN_ZERO;
                  if (iMUTE) begin
                     state_d = ST_MUTED;
                  end else begin
                     cur_sel_d = tgt_d;
                     state_d   = ST_FADE_IN;
                  end
               end else begin
                  gain_d = gain_q - GAIN_ONE;
               end
            end
            ST_FADE_IN: begin
               if (iMUTE || (!iMODE && (iSEL != cur_sel_q))) begin
                  // Reverse from the current gain so the level never jumps
                  tgt_d   = iMODE ? tgt_q : iSEL;
                  state_d = ST_FADE_OUT;
                  gain_d  = gain_q - GAIN_ONE;
               end else if (gain_q >= GAIN_FULL) begin
                  state_d = ST_IDLE;
                  gain_d  = GAIN_FULL;
               end else begin
                  gain_d = gain_q + GAIN_ONE;
               end
            end
            ST_MUTED: begin
               gain_d = GAIN_ZERO;
               tgt_d  = iMODE ? tgt_q : iSEL;
               if (!iMUTE) begin
                  cur_sel_d = tgt_d;
                  state_d   = ST_FADE_IN;
                  gain_d    = GAIN_ONE;
               end else begin
                  state_d = ST_MUTED;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               gain_d    = GAIN_FULL;
               cur_sel_d = '0;
               tgt_d     = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Source multiplexer driven by the post-tick selection
   always_comb begin
      sel_l_s = '0;
      sel_r_s = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         sel_l_s = (cur_sel_d == SEL_W'(k)) ? iSRC_L[k*DATA_W +: DATA_W] : sel_l_s;
         sel_r_s = (cur_sel_d == SEL_W'(k)) ? iSRC_R[k*DATA_W +: DATA_W] : sel_r_s;
      end
      raw_l_s = iMODE ? sum_l_s : sel_l_s;
      raw_r_s = iMODE ? sum_r_s : sel_r_s;
   end

   // Output next-state: new samples and flags only on a tick
   always_comb begin
      valid_d = iSAMPLE_TICK;
      if (iSAMPLE_TICK) begin
         l_d      = scale(raw_l_s, gain_d, iVOL);
         r_d      = scale(raw_r_s, gain_d, iVOL);
         fading_d = (state_d == ST_FADE_OUT) || (state_d == ST_FADE_IN);
      end else begin
         l_d      = l_q;
         r_d      = r_q;
         fading_d = fading_q;
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= ST_IDLE;
         gain_q    <= GAIN_FULL;
         cur_sel_q <= '0;
         tgt_q     <= '0;
         l_q       <= '0;
         r_q       <= '0;
         valid_q   <= 1'b0;
         fading_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         gain_q    <= gain_d;
         cur_sel_q <= cur_sel_d;
         tgt_q     <= tgt_d;
         l_q       <= l_d;
         r_q       <= r_d;
         valid_q   <= valid_d;
         fading_q  <= fading_d;
      end
   end

   assign oL      = l_q;
   assign oR      = r_q;
   assign oVALID  = valid_q;
   assign oFADING = fading_q;

endmodule

// File: tb/tb_audio_source_mixer.sv
// -----------------------------------------------------------------------------
// tb_audio_source_mixer
// Directed and randomized stimulus for audio_source_mixer (4 sources, 16-bit,
// 16-step fades) checked against an integer reference model of the fade rules.
// -----------------------------------------------------------------------------
module tb_audio_source_mixer;

   localparam int M_IDLE  = 0;
   localparam int M_OUT   = 1;
   localparam int M_IN    = 2;
   localparam int M_MUTED = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic [63:0] src_l_v, src_r_v;
   logic [1:0]  sel;
   logic        mode, mute;
   logic [2:0]  vol;
   logic [15:0] ol_w, or_w;
   logic        val_w, fad_w;

   int src_l[4];
   int src_r[4];
   int total = 0;
   int bad   = 0;

   // reference model state
   int m_st, m_gain, m_cur, m_tgt;
   int e_l, e_r;

   audio_source_mixer #(.NUM_SRC(4), .DATA_W(16), .FADE_STEPS(16)) dut (
      .iCLK         (clk),
      .iRST_N       (rst_n),
      .iSAMPLE_TICK (tick),
      .iSRC_L       (src_l_v),
      .iSRC_R       (src_r_v),
      .iSEL         (sel),
      .iMODE        (mode),
      .iMUTE        (mute),
      .iVOL         (vol),
      .oL           (ol_w),
      .oR           (or_w),
      .oVALID       (val_w),
      .oFADING      (fad_w)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int s16(input int v);
      int t;
      t = v & 32'hFFFF;
      return (t >= 32768) ? t - 65536 : t;
   endfunction

   function automatic int fdiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic int model_out(input int s[4]);
      int raw;
      if (mode) begin
         raw = 0;
         for (int k = 0; k < 4; k++) raw += s16(s[k]);
         if (raw > 32767)  raw = 32767;
         if (raw < -32768) raw = -32768;
      end else begin
         raw = s16(s[m_cur]);
      end
      return fdiv(fdiv(raw * m_gain, 16), 1 << int'(vol)) & 32'hFFFF;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_gain = 16; m_cur = 0; m_tgt = 0;
   endtask

   // Advance the model by one sample using the current input settings
   task automatic model_tick();
      int s;
      s = int'(sel);
      if (m_st == M_IDLE) begin
         m_gain = 16;
         if (mute) begin
            m_st = M_OUT; m_gain = 15;
         end else if (!mode && s != m_cur) begin
            m_tgt = s; m_st = M_OUT; m_gain = 15;
         end
      end else if (m_st == M_OUT) begin
         if (!mode) m_tgt = s;
         if (m_gain <= 1) begin
            m_gain = 0;
            if (mute) m_st = M_MUTED;
            else begin m_cur = m_tgt; m_st = M_IN; end
         end else m_gain--;
      end else if (m_st == M_IN) begin
         if (mute || (!mode && s != m_cur)) begin
            if (!mode) m_tgt = s;
            m_st = M_OUT; m_gain--;
         end else if (m_gain >= 16) m_st = M_IDLE;
         else m_gain++;
      end else begin
         m_gain = 0;
         if (!mode) m_tgt = s;
         if (!mute) begin m_cur = m_tgt; m_st = M_IN; m_gain = 1; end
      end
   endtask

   // One sample: tick, check the update, then check a quiet cycle holds
   task automatic step(input string tag);
      for (int k = 0; k < 4; k++) begin
         src_l_v[k*16 +: 16] = 16'(src_l[k]);
         src_r_v[k*16 +: 16] = 16'(src_r[k]);
      end
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      model_tick();
      e_l = model_out(src_l);
      e_r = model_out(src_r);
      chk({tag, ".L"},   32'(ol_w),  32'(e_l));
      chk({tag, ".R"},   32'(or_w),  32'(e_r));
      chk({tag, ".vld"}, 32'(val_w), 32'd1);
      chk({tag, ".fad"}, 32'(fad_w), (m_st == M_OUT || m_st == M_IN) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk({tag, ".vld0"},  32'(val_w), 32'd0);
      chk({tag, ".holdL"}, 32'(ol_w),  32'(e_l));
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; sel = 2'd0; mode = 1'b0; mute = 1'b0; vol = 3'd0;
      src_l_v = 64'd0; src_r_v = 64'd0;
      for (int k = 0; k < 4; k++) begin src_l[k] = 0; src_r[k] = 0; end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.L",   32'(ol_w),  32'd0);
      chk("rst.R",   32'(or_w),  32'd0);
      chk("rst.vld", 32'(val_w), 32'd0);
      chk("rst.fad", 32'(fad_w), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // first sample after reset: source 0 at full gain
      src_l[0] = 32'h1000; src_r[0] = 32'h0800;
      step("first");
      chk("first.const", 32'(ol_w), 32'h1000);

      // mix mode saturation, both directions
      mode = 1'b1;
      for (int k = 0; k < 4; k++) begin src_l[k] = 32'h7000; src_r[k] = 32'h0100; end
      step("mixpos");
      chk("mixpos.const", 32'(ol_w), 32'h7FFF);
      for (int k = 0; k < 4; k++) begin src_l[k] = 32'h9000; src_r[k] = 32'hFF00; end
      step("mixneg");
      chk("mixneg.const", 32'(ol_w), 32'h8000);

      // source switch 0 -> 2: fade out then in
      mode = 1'b0;
      for (int k = 0; k < 4; k++) begin src_l[k] = 0; src_r[k] = 0; end
      src_l[0] = 32'h1000; src_l[2] = 32'h2000; src_r[2] = 32'h0400;
      step("presw");
      sel = 2'd2;
      for (int i = 0; i < 32; i++) begin
         step("sw");
         chk("sw.const", 32'(ol_w), (i < 16) ? 32'(32'h0F00 - i * 32'h100) : 32'((i - 15) * 32'h200));
         chk("sw.fad", 32'(fad_w), 32'd1);
      end
      step("swdone");
      chk("swdone.fad", 32'(fad_w), 32'd0);

      // mute and unmute
      mute = 1'b1;
      for (int i = 0; i < 16; i++) step("mute");
      chk("muted.L",   32'(ol_w),  32'd0);
      chk("muted.fad", 32'(fad_w), 32'd0);
      mute = 1'b0;
      for (int i = 0; i < 16; i++) step("unmute");
      chk("unmuted.L", 32'(ol_w), 32'h2000);
      step("unmute.end");

      // volume shift floors toward minus infinity
      vol = 3'd3;
      src_l[2] = 32'hFFFF;
      step("vol.neg");
      chk("vol.neg.const", 32'(ol_w), 32'hFFFF);
      src_l[2] = 32'h0008;
      step("vol.pos");
      chk("vol.pos.const", 32'(ol_w), 32'h0001);
      vol = 3'd0;

      // asynchronous reset in the middle of a fade-in
      sel = 2'd1; src_l[1] = 32'h0C00;
      for (int i = 0; i < 19; i++) step("prerst");
      #3 rst_n = 1'b0;
      #1;
      chk("arst.L",   32'(ol_w),  32'd0);
      chk("arst.vld", 32'(val_w), 32'd0);
      chk("arst.fad", 32'(fad_w), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      model_reset();
      sel = 2'd0; src_l[0] = 32'h1234;
      @(posedge clk); #1;
      step("postrst");
      chk("postrst.const", 32'(ol_w), 32'h1234);

      // randomized sequence against the model
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 4; k++) begin
            src_l[k] = int'($urandom_range(0, 65535));
            src_r[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 65535));
         end
         if ($urandom_range(0, 7) == 0)   sel  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0)  mode = ~mode;
         if ($urandom_range(0, 29) == 0)  mute = ~mute;
         vol = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
